// File: rtl/unpack_16to12_pkg.sv
// rtl/unpack_16to12_pkg.sv - shared data-type codes and header constants for the 12-bit unpacker
package unpack_16to12_pkg;
    localparam int DTYPE_WIDTH = 4;

    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_START = 4'h1;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER       = 4'h2;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_END   = 4'h3;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START  = 4'h4;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END    = 4'h5;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL        = 4'h8;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK   = 4'h8;

    // Header word index holding image_type, and the packed-12 marker shared with the packer
    localparam logic [7:0] Image_image_type    = 8'd2;
    localparam logic [4:0] IMAGE_TYPE_PACKED12 = 5'h10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_FRAME
    } stream_state_e;

    function automatic logic is_pixel(input logic [DTYPE_WIDTH-1:0] dt);
        return |(dt & DTYPE_PIXEL_MASK);
    endfunction
endpackage

// File: rtl/unpack_16to12_dtype_queue.sv
// rtl/unpack_16to12_dtype_queue.sv - {dtype,data} FIFO with dual push, single pop and drop indication
module dtype_queue #(
    parameter int DEPTH = 2,
    parameter int TW    = 4,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          push0_valid,
    input  logic [TW-1:0] push0_dtype,
    input  logic [DW-1:0] push0_data,
    input  logic          push1_valid,
    input  logic [TW-1:0] push1_dtype,
    input  logic [DW-1:0] push1_data,
    output logic          dvo,
    output logic [TW-1:0] dtypeo,
    output logic [DW-1:0] datao,
    output logic          drop
);
    localparam int EW = TW + DW;
    localparam int LW = DEPTH + 1;
    localparam int CW = $clog2(DEPTH + 3);

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [EW-1:0] list  [LW];
    logic [CW-1:0] count_q, count_d, total;
    logic          dvo_q, dvo_d;
    logic [EW-1:0] out_q, out_d;

    // Stored entries followed by this cycle's pushes; the head pops straight into the output register
    always_comb begin
        for (int i = 0; i < LW; i++) list[i] = '0;
        for (int i = 0; i < DEPTH; i++) list[i] = mem_q[i];
        for (int i = 0; i < LW; i++) begin
            if (push0_valid && i == int'(count_q)) list[i] = {push0_dtype, push0_data};
            if (push0_valid && push1_valid && i == int'(count_q) + 1) list[i] = {push1_dtype, push1_data};
        end
        total   = count_q + CW'(push0_valid) + CW'(push0_valid & push1_valid);
        dvo_d   = 1'b0;
        out_d   = out_q;
        count_d = '0;
        drop    = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_d[i] = list[i+1];
        if (total != '0) begin
            dvo_d = 1'b1;
            out_d = list[0];
            if (int'(total) > DEPTH + 1) begin
                count_d = CW'(DEPTH);
                drop    = 1'b1;
            end else begin
                count_d = total - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            count_q <= '0;
            dvo_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            count_q <= count_d;
            dvo_q   <= dvo_d;
            out_q   <= out_d;
        end
    end

    assign dvo    = dvo_q;
    assign dtypeo = out_q[EW-1:DW];
    assign datao  = out_q[DW-1:0];
endmodule

// File: rtl/unpack_16to12.sv
// rtl/unpack_16to12.sv - restores four 12-bit pixels from every three packed 16-bit words
module unpack_16to12
    import unpack_16to12_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic                   enable,
    input  logic [4:0]             unpacked_type,
    input  logic                   dvi,
    input  logic [DTYPE_WIDTH-1:0] dtypei,
    input  logic [15:0]            datai,
    output logic                   dvo,
    output logic [DTYPE_WIDTH-1:0] dtypeo,
    output logic [15:0]            datao,
    output logic [15:0]            frame_count,
    output logic                   overflow,
    output logic                   misaligned
);
    stream_state_e state_q, state_d;
    logic [7:0]  header_addr_q, header_addr_d;
    logic        packed_hdr_q, packed_hdr_d;
    logic        active_q, active_d;
    logic        enable_s_q, enable_s_d;
    logic [1:0]  phase_q, phase_d;
    logic [3:0]  lo4_q, lo4_d;
    logic [7:0]  lo8_q, lo8_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        overflow_q, overflow_d;
    logic        misaligned_q, misaligned_d;

    logic                   push0_valid, push1_valid, q_drop;
    logic [15:0]            push0_data, push1_data;

    always_comb begin
        state_d       = state_q;
        header_addr_d = header_addr_q;
        packed_hdr_d  = packed_hdr_q;
        active_d      = active_q;
        enable_s_d    = enable;
        phase_d       = phase_q;
        lo4_d         = lo4_q;
        lo8_d         = lo8_q;
        frame_count_d = frame_count_q;
        overflow_d    = overflow_q | q_drop;
        misaligned_d  = misaligned_q;
        push0_valid   = dvi;
        push0_data    = datai;
        push1_valid   = 1'b0;
        push1_data    = {4'h0, datai[11:0]};
        if (dvi) begin
            case (dtypei)
                DTYPE_HEADER_START: begin
                    state_d       = ST_HEADER;
                    header_addr_d = '0;
                end
                DTYPE_HEADER: begin
                    header_addr_d = header_addr_q + 8'd1;
                    if (header_addr_q == Image_image_type && datai[4:0] == IMAGE_TYPE_PACKED12) begin
                        packed_hdr_d = 1'b1;
                        if (enable_s_q) push0_data = {datai[15:5], unpacked_type};
                    end
                end
                DTYPE_HEADER_END: state_d = ST_IDLE;
                DTYPE_FRAME_START: begin
                    state_d       = ST_FRAME;
                    active_d      = enable_s_q & packed_hdr_q;
                    packed_hdr_d  = 1'b0;
                    phase_d       = 2'd0;
                    frame_count_d = frame_count_q + 16'd1;
                end
                DTYPE_FRAME_END: begin
                    state_d = ST_IDLE;
                    if (phase_q != 2'd0) misaligned_d = 1'b1;
                end
                default: ;
            endcase
            // Pixel words: 3 packed words carry pixels as {p0,p1lo}, {p1hi,p2lo}, {p2hi,p3}
            if (is_pixel(dtypei) && active_q && state_q == ST_FRAME) begin
                case (phase_q)
                    2'd0: begin
                        push0_data = {4'h0, datai[15:4]};
                        lo4_d      = datai[3:0];
                        phase_d    = 2'd1;
                    end
                    2'd1: begin
                        push0_data = {4'h0, datai[15:8], lo4_q};
                        lo8_d      = datai[7:0];
                        phase_d    = 2'd2;
                    end
                    default: begin
                        push0_data  = {4'h0, datai[15:12], lo8_q};
                        push1_valid = 1'b1;
                        phase_d     = 2'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q       <= ST_IDLE;
            header_addr_q <= '0;
            packed_hdr_q  <= 1'b0;
            active_q      <= 1'b0;
            enable_s_q    <= 1'b0;
            phase_q       <= 2'd0;
            lo4_q         <= '0;
            lo8_q         <= '0;
            frame_count_q <= '0;
            overflow_q    <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            header_addr_q <= header_addr_d;
            packed_hdr_q  <= packed_hdr_d;
            active_q      <= active_d;
            enable_s_q    <= enable_s_d;
            phase_q       <= phase_d;
            lo4_q         <= lo4_d;
            lo8_q         <= lo8_d;
            frame_count_q <= frame_count_d;
            overflow_q    <= overflow_d;
            misaligned_q  <= misaligned_d;
        end
    end

    dtype_queue #(
        .DEPTH (QDEPTH),
        .TW    (DTYPE_WIDTH),
        .DW    (16)
    ) u_queue (
        .clk         (clk),
        .resetb      (resetb),
        .push0_valid (push0_valid),
        .push0_dtype (dtypei),
        .push0_data  (push0_data),
        .push1_valid (push1_valid),
        .push1_dtype (dtypei),
        .push1_data  (push1_data),
        .dvo         (dvo),
        .dtypeo      (dtypeo),
        .datao       (datao),
        .drop        (q_drop)
    );

    assign frame_count = frame_count_q;
    assign overflow    = overflow_q;
    assign misaligned  = misaligned_q;
endmodule

// File: tb/tb_unpack_16to12.sv
// tb/tb_unpack_16to12.sv - self-checking bench for unpack_16to12
module tb_unpack_16to12;
    import unpack_16to12_pkg::*;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        enable = 1'b1;
    logic [4:0]  unpacked_type = 5'h0C;
    logic        dvi = 1'b0;
    logic [3:0]  dtypei = '0;
    logic [15:0] datai = '0;
    logic        dvo;
    logic [3:0]  dtypeo;
    logic [15:0] datao;
    logic [15:0] frame_count;
    logic        overflow;
    logic        misaligned;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [3:0]  dt;
        logic [15:0] din;
        int          nexp;
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;

    localparam int NV = 10;
    vec_t tbl [NV];

    logic [19:0] out_q [$];
    logic        pass_chk = 1'b0;
    logic        dvi_prev = 1'b0;
    int          pass_err = 0;

    unpack_16to12 #(.QDEPTH(2)) dut (
        .clk           (clk),
        .resetb        (resetb),
        .enable        (enable),
        .unpacked_type (unpacked_type),
        .dvi           (dvi),
        .dtypei        (dtypei),
        .datai         (datai),
        .dvo           (dvo),
        .dtypeo        (dtypeo),
        .datao         (datao),
        .frame_count   (frame_count),
        .overflow      (overflow),
        .misaligned    (misaligned)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dvo) out_q.push_back({dtypeo, datao});
        if (pass_chk && dvo !== dvi_prev) pass_err++;
        dvi_prev = dvi;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [3:0] dt, input logic [15:0] d);
        @(posedge clk); #1;
        dvi = 1'b1; dtypei = dt; datai = d;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            dvi = 1'b0; dtypei = '0; datai = '0;
        end
    endtask

    function automatic logic [11:0] pix(input int k);
        return 12'(k * 37 + 5);
    endfunction

    // Packs pixels 4g..4g+3 into three words and sends them back to back
    task automatic send_group(input int g);
        logic [11:0] p0, p1, p2, p3;
        p0 = pix(4*g); p1 = pix(4*g+1); p2 = pix(4*g+2); p3 = pix(4*g+3);
        send_word(DTYPE_PIXEL, {p0, p1[3:0]});
        send_word(DTYPE_PIXEL, {p1[11:4], p2[7:0]});
        send_word(DTYPE_PIXEL, {p2[11:8], p3});
    endtask

    task automatic send_header(input logic [15:0] hdr);
        send_word(DTYPE_HEADER_START, 16'h0000);
        send_word(DTYPE_HEADER, 16'h1111);
        send_word(DTYPE_HEADER, 16'h2222);
        send_word(DTYPE_HEADER, hdr);
        send_word(DTYPE_HEADER_END, 16'h0000);
        send_word(DTYPE_FRAME_START, 16'h0000);
    endtask

    task automatic run_table(input bit unpack, input logic [15:0] hdr, input string tag);
        logic [19:0] exp_q [$];
        logic [15:0] d;
        out_q.delete();
        for (int i = 0; i < NV; i++) begin
            d = (i == 3) ? hdr : tbl[i].din;
            send_word(tbl[i].dt, d);
            idle(1);
            if (unpack) begin
                exp_q.push_back({tbl[i].dt, tbl[i].e0});
                if (tbl[i].nexp == 2) exp_q.push_back({tbl[i].dt, tbl[i].e1});
            end else begin
                exp_q.push_back({tbl[i].dt, d});
            end
        end
        idle(6);
        check({tag, " count"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            check($sformatf("%s entry%0d", tag, i), out_q[i], exp_q[i]);
    endtask

    initial begin
        int n;
        int perr;
        tbl[0] = '{DTYPE_HEADER_START, 16'h0000, 1, 16'h0000, 16'h0000};
        tbl[1] = '{DTYPE_HEADER,       16'h1111, 1, 16'h1111, 16'h0000};
        tbl[2] = '{DTYPE_HEADER,       16'h2222, 1, 16'h2222, 16'h0000};
        tbl[3] = '{DTYPE_HEADER,       16'hFF10, 1, 16'hFF0C, 16'h0000};
        tbl[4] = '{DTYPE_HEADER_END,   16'h0000, 1, 16'h0000, 16'h0000};
        tbl[5] = '{DTYPE_FRAME_START,  16'h0000, 1, 16'h0000, 16'h0000};
        tbl[6] = '{DTYPE_PIXEL,        16'hABC1, 1, 16'h0ABC, 16'h0000};
        tbl[7] = '{DTYPE_PIXEL,        16'h2345, 1, 16'h0231, 16'h0000};
        tbl[8] = '{DTYPE_PIXEL,        16'h6789, 2, 16'h0645, 16'h0789};
        tbl[9] = '{DTYPE_FRAME_END,    16'h0000, 1, 16'h0000, 16'h0000};

        repeat (2) @(negedge clk);
        check("reset dvo", dvo, 0);
        check("reset dtypeo", dtypeo, 0);
        check("reset datao", datao, 0);
        check("reset frame_count", frame_count, 0);
        check("reset overflow", overflow, 0);
        check("reset misaligned", misaligned, 0);
        @(posedge clk); #1;
        resetb = 1'b1;
        idle(3);

        run_table(1'b1, 16'hFF10, "unpack");
        check("frame_count after unpack", frame_count, 1);

        enable = 1'b0;
        idle(3);
        pass_chk = 1'b1;
        run_table(1'b0, 16'hFF10, "enable0");
        check("frame_count after enable0", frame_count, 2);

        enable = 1'b1;
        idle(3);
        run_table(1'b0, 16'hFF03, "not_packed");
        pass_chk = 1'b0;
        check("pass-through dvo timing errors", pass_err, 0);
        check("frame_count after not_packed", frame_count, 3);

        // 3/4 duty: 300 packed words must come out as 400 pixels with nothing lost
        out_q.delete();
        send_header(16'hFF10);
        for (int g = 0; g < 100; g++) begin
            send_group(g);
            idle(1);
        end
        send_word(DTYPE_FRAME_END, 16'h0000);
        idle(6);
        check("duty count", out_q.size(), 407);
        perr = 0;
        for (int k = 0; k < 400 && 6 + k < out_q.size(); k++)
            if (out_q[6+k] !== {DTYPE_PIXEL, 4'h0, pix(k)}) perr++;
        check("duty pixel errors", perr, 0);
        check("duty overflow", overflow, 0);
        check("duty misaligned", misaligned, 0);

        // Frame ends after 4 packed words: phase 1 on FRAME_END
        out_q.delete();
        send_header(16'hFF10);
        send_group(0);
        send_word(DTYPE_PIXEL, {pix(4), pix(5)[3:0]});
        send_word(DTYPE_FRAME_END, 16'h0000);
        idle(6);
        check("misaligned flag", misaligned, 1);
        check("misaligned count", out_q.size(), 12);
        if (out_q.size() > 10) check("misaligned residual pixel", out_q[10], {DTYPE_PIXEL, 4'h0, pix(4)});

        out_q.delete();
        send_header(16'hFF10);
        send_group(5);
        send_word(DTYPE_FRAME_END, 16'h0000);
        idle(6);
        check("realign count", out_q.size(), 11);
        for (int k = 0; k < 4 && 6 + k < out_q.size(); k++)
            check($sformatf("realign pixel%0d", k), out_q[6+k], {DTYPE_PIXEL, 4'h0, pix(20 + k)});

        // 12 packed words back to back overflow a 2-deep queue
        check("overflow before burst", overflow, 0);
        out_q.delete();
        send_header(16'hFF10);
        for (int g = 0; g < 4; g++) send_group(g);
        idle(4);
        send_word(DTYPE_FRAME_END, 16'h0000);
        idle(6);
        check("burst overflow", overflow, 1);
        for (int k = 0; k < 8 && 6 + k < out_q.size(); k++)
            check($sformatf("burst pixel%0d", k), out_q[6+k], {DTYPE_PIXEL, 4'h0, pix(k)});

        // Reset with entries queued mid-frame
        send_header(16'hFF10);
        send_group(0);
        send_group(1);
        @(posedge clk); #1;
        dvi = 1'b0; dtypei = '0; datai = '0;
        resetb = 1'b0;
        #1;
        check("midreset dvo", dvo, 0);
        check("midreset datao", datao, 0);
        check("midreset dtypeo", dtypeo, 0);
        check("midreset overflow", overflow, 0);
        check("midreset misaligned", misaligned, 0);
        check("midreset frame_count", frame_count, 0);
        n = out_q.size();
        idle(2);
        resetb = 1'b1;
        idle(8);
        check("no output after reset", out_q.size(), n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
